// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared types for the systolic-array processing elements.
//   pe_cmd_e   : command encoding carried on the 2-bit cmd port
//   pe_state_e : PE control states (accumulate, flush pipe, drain psum)
//   is_action  : true for any command that makes the PE leave ST_ACC
// -----------------------------------------------------------------------------
package tpu_pkg;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      CMD_CLEAR = 2'd1,
      CMD_LOAD  = 2'd2,
      CMD_DRAIN = 2'd3
   } pe_cmd_e;

   typedef enum logic [1:0] {
      ST_ACC   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } pe_state_e;

   // NOP is the only command that leaves the PE accumulating
   function automatic logic is_action(input pe_cmd_e c);
      return (c != CMD_NOP);
   endfunction

endpackage

// File: rtl/pe_mac_pipe.sv
// -----------------------------------------------------------------------------
// pe_mac_pipe
// Two-stage signed multiply-accumulate pipe of one PE.
//   S1: p <= x*y (full 2*DATA_W signed product), p_vld <= op_vld
//   S2: acc += sext(p) when p_vld; acc_clear / acc_load override the add
// Configuration macro: SATURATE_EN
//   defined   : S2 add clamps to the signed ACC_W range, sat_flag sticky on clamp
//   undefined : S2 add wraps modulo 2^ACC_W, sat_flag tied 0
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   x, y, op_vld      operands and their (already accept-qualified) valid
//   acc_clear         zero the accumulator and sat_flag
//   acc_load          load load_data into the accumulator, clear sat_flag
//   load_data         value for acc_load
//   p_vld             S1 product valid (product still in flight)
//   acc               accumulator value
//   sat_flag          sticky saturation indicator
// -----------------------------------------------------------------------------
module pe_mac_pipe
   import tpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] y,
   input  logic                     op_vld,
   input  logic                     acc_clear,
   input  logic                     acc_load,
   input  logic        [ACC_W-1:0]  load_data,
   output logic                     p_vld,
   output logic        [ACC_W-1:0]  acc,
   output logic                     sat_flag
);

   localparam int PW = 2 * DATA_W;

   logic signed [PW-1:0]    p_r;
   logic                    p_vld_r;
   logic        [ACC_W-1:0] p_ext_s;
   logic        [ACC_W-1:0] acc_r;
   logic        [ACC_W-1:0] add_res_s;

   // sign extension of the product to accumulator width
   assign p_ext_s = ACC_W'(p_r);

   // S1: register the full-width product and its valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_r     <= {PW{1'b0}};
         p_vld_r <= 1'b0;
      end else begin
         p_r     <= PW'(x) * PW'(y);
         p_vld_r <= op_vld;
      end
   end

`ifdef SATURATE_EN
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] sum_s;
   logic           clamp_s;
   logic           sat_r;

   // S2 adder, one guard bit detects signed overflow; clamp toward its sign
   always_comb begin
      sum_s   = {acc_r[ACC_W-1], acc_r} + {p_ext_s[ACC_W-1], p_ext_s};
      clamp_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
      if (clamp_s) begin
         if (sum_s[ACC_W]) begin
            add_res_s = ACC_MIN;
         end else begin
            add_res_s = ACC_MAX;
         end
      end else begin
         add_res_s = sum_s[ACC_W-1:0];
      end
   end

   // sticky saturation flag, cleared only by CLEAR/LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_r <= 1'b0;
      end else if (acc_clear || acc_load) begin
         sat_r <= 1'b0;
      end else if (p_vld_r && clamp_s) begin
         sat_r <= 1'b1;
      end
   end

   assign sat_flag = sat_r;
`else
   // S2 adder, plain modulo-2^ACC_W wrap
   always_comb begin
      add_res_s = acc_r + p_ext_s;
   end

   assign sat_flag = 1'b0;
`endif

   // S2: accumulator; clear/load only fire when no product is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (acc_clear) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (acc_load) begin
         acc_r <= load_data;
      end else if (p_vld_r) begin
         acc_r <= add_res_s;
      end
   end

   assign p_vld = p_vld_r;
   assign acc   = acc_r;

endmodule

// File: rtl/systolic_mac_pe.sv
// -----------------------------------------------------------------------------
// systolic_mac_pe
// Output-stationary signed MAC processing element of the systolic array.
// Forwards x east and y south one cycle late, accumulates x*y locally through
// a 2-stage pipe (pe_mac_pipe), and accepts CLEAR / LOAD / DRAIN commands.
// DRAIN shifts the accumulator, then the upstream PEs' values, down the psum
// chain over 1+CHAIN_POS cycles so the bottom PE emits a whole column.
// Configuration macro: SATURATE_EN (saturating accumulate, see pe_mac_pipe).
// Ports:
//   MCLK, RSTN                 clock, asynchronous active-low reset
//   x_in, y_in, op_vld_in      operands from west/north and their valid
//   x_out, y_out, op_vld_out   registered forwarded operands / valid
//   cmd, cmd_vld, load_data    command (NOP/CLEAR/LOAD/DRAIN), strobe, LOAD value
//   psum_in, psum_vld_in       psum chain from the upstream PE
//   psum_out, psum_vld_out     psum chain to the downstream PE
//   busy                       PE not in ST_ACC
//   op_drop                    valid operand arrived while busy (1 cycle late)
//   sat_flag                   sticky saturation indicator
// -----------------------------------------------------------------------------
module systolic_mac_pe
   import tpu_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 32,
   parameter int CHAIN_POS = 0
) (
   input  logic              MCLK,
   input  logic              RSTN,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] y_in,
   input  logic              op_vld_in,
   output logic [DATA_W-1:0] x_out,
   output logic [DATA_W-1:0] y_out,
   output logic              op_vld_out,
   input  logic [1:0]        cmd,
   input  logic              cmd_vld,
   input  logic [ACC_W-1:0]  load_data,
   input  logic [ACC_W-1:0]  psum_in,
   input  logic              psum_vld_in,
   output logic [ACC_W-1:0]  psum_out,
   output logic              psum_vld_out,
   output logic              busy,
   output logic              op_drop,
   output logic              sat_flag
);

   localparam int CNT_W = $clog2(CHAIN_POS + 1) + 1;

   if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
      $error("systolic_mac_pe: ACC_W must be at least 2*DATA_W");
   end

   pe_state_e          state_r;
   pe_state_e          state_nx_s;
   pe_cmd_e            cmd_r;
   logic [ACC_W-1:0]   load_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               busy_r;
   logic [DATA_W-1:0]  x_r;
   logic [DATA_W-1:0]  y_r;
   logic               op_vld_r;
   logic               op_drop_r;
   logic [ACC_W-1:0]   psum_r;
   logic               psum_vld_r;

   logic               accept_s;
   logic               cmd_go_s;
   logic               apply_s;
   logic               acc_clear_s;
   logic               acc_load_s;
   logic               cnt_last_s;
   logic               p_vld_s;
   logic [ACC_W-1:0]   acc_s;
   logic               sat_flag_s;

   assign accept_s    = (state_r == ST_ACC);
   assign cmd_go_s    = accept_s && cmd_vld && is_action(pe_cmd_e'(cmd));
   // the captured command acts once the op accepted with it has left S1
   assign apply_s     = (state_r == ST_FLUSH) && !p_vld_s;
   assign acc_clear_s = apply_s && (cmd_r == CMD_CLEAR);
   assign acc_load_s  = apply_s && (cmd_r == CMD_LOAD);
   assign cnt_last_s  = (cnt_r == CNT_W'(CHAIN_POS));

   pe_mac_pipe #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_pipe (
      .clk       (MCLK),
      .rst_n     (RSTN),
      .x         (x_in),
      .y         (y_in),
      .op_vld    (op_vld_in && accept_s),
      .acc_clear (acc_clear_s),
      .acc_load  (acc_load_s),
      .load_data (load_r),
      .p_vld     (p_vld_s),
      .acc       (acc_s),
      .sat_flag  (sat_flag_s)
   );

   // next-state decode of the command FSM
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_ACC: begin
            if (cmd_go_s) begin
               state_nx_s = ST_FLUSH;
            end else begin
               state_nx_s = ST_ACC;
            end
         end
         ST_FLUSH: begin
            if (!p_vld_s) begin
               if (cmd_r == CMD_DRAIN) begin
                  state_nx_s = ST_DRAIN;
               end else begin
                  state_nx_s = ST_ACC;
               end
            end else begin
               state_nx_s = ST_FLUSH;
            end
         end
         ST_DRAIN: begin
            if (cnt_last_s) begin
               state_nx_s = ST_ACC;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            state_nx_s = ST_ACC;
         end
      endcase
   end

   // state register; busy is registered from the next-state decode
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         state_r <= ST_ACC;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s != ST_ACC);
      end
   end

   // capture command and LOAD value at accept; later commands are ignored
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         cmd_r  <= CMD_NOP;
         load_r <= {ACC_W{1'b0}};
      end else if (cmd_go_s) begin
         cmd_r  <= pe_cmd_e'(cmd);
         load_r <= load_data;
      end
   end

   // drain cycle counter, runs 0..CHAIN_POS while in ST_DRAIN
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_DRAIN) && !cnt_last_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= {CNT_W{1'b0}};
      end
   end

   // psum chain: own acc first, then pass upstream values through
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         psum_r     <= {ACC_W{1'b0}};
         psum_vld_r <= 1'b0;
      end else if (state_r == ST_DRAIN) begin
         if (cnt_r == {CNT_W{1'b0}}) begin
            psum_r     <= acc_s;
            psum_vld_r <= 1'b1;
         end else begin
            psum_r     <= psum_in;
            psum_vld_r <= psum_vld_in;
         end
      end else begin
         psum_vld_r <= 1'b0;
      end
   end

   // operand forwarding (all states) and dropped-operand pulse
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         x_r       <= {DATA_W{1'b0}};
         y_r       <= {DATA_W{1'b0}};
         op_vld_r  <= 1'b0;
         op_drop_r <= 1'b0;
      end else begin
         op_vld_r  <= op_vld_in;
         op_drop_r <= op_vld_in && !accept_s;
         if (op_vld_in) begin
            x_r <= x_in;
            y_r <= y_in;
         end
      end
   end

   assign x_out        = x_r;
   assign y_out        = y_r;
   assign op_vld_out   = op_vld_r;
   assign psum_out     = psum_r;
   assign psum_vld_out = psum_vld_r;
   assign busy         = busy_r;
   assign op_drop      = op_drop_r;
   assign sat_flag     = sat_flag_s;

endmodule
